axi4_lite_reg_file: RTL and testbench



---
 rtl/axi4_lite_reg_file.sv | 224 ++++++++++++++++++++++
 tb/tb_axi4_lite_reg_file.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_reg_file.sv
// AXI4-lite slave register file: REGS words of 8*N bits, byte strobes, SLVERR on RO/out-of-range.
// Latency: write commit, bvalid and wr_pulse one cycle after the second of AW/W; rdata/rvalid one cycle after AR.
// Backpressure: each path holds its response until bready/rready and stalls its readys meanwhile.
// Ports: AXI4-lite AW/W/B/AR/R channels on aclk/areset; reg_q exposes RW contents, status_d feeds
// read-only slots, wr_pulse/rd_pulse give one-cycle per-register strobes to the surrounding logic.
module axi4_lite_reg_file #(
    parameter int                  A         = 12,
    parameter int                  N         = 4,
    parameter int                  REGS      = 16,
    parameter int                  USE_STRB  = 1,
    parameter logic [REGS-1:0]     RO_MASK   = '0,
    parameter logic [REGS*8*N-1:0] RESET_VAL = '0
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [A-1:0]          awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [8*N-1:0]        wdata,
    input  logic [N-1:0]          wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [A-1:0]          araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [8*N-1:0]        rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [REGS*8*N-1:0]   reg_q,
    input  logic [REGS*8*N-1:0]   status_d,
    output logic [REGS-1:0]       wr_pulse,
    output logic [REGS-1:0]       rd_pulse
);
    localparam int DW = 8 * N;
    localparam int L  = $clog2(N);
    localparam int IW = A - L;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_RESP} rstate_t;

    wstate_t wst;
    rstate_t rst;

    // RO slots are never written and reset to 0, so reg_q shows 0 there.
    logic [REGS-1:0][DW-1:0] regs;

    logic [IW-1:0]   aw_idx_q;
    logic [DW-1:0]   wdata_q;
    logic [N-1:0]    wstrb_q;

    logic            aw_hs, w_hs, ar_hs;
    logic            commit;
    logic [IW-1:0]   c_idx;
    logic [DW-1:0]   c_data;
    logic [N-1:0]    c_strb;
    logic [IW-1:0]   ar_idx;
    logic [REGS-1:0] wsel, rsel;
    logic            w_err;
    logic [DW-1:0]   rd_word;

    assign reg_q  = regs;
    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign ar_hs  = arvalid && arready;
    assign ar_idx = araddr[A-1:L];

    // Sub-word address bits carry no meaning for a word-addressed file.
    generate
        if (L > 0) begin : g_lsb
            logic unused_addr_lsb;
            assign unused_addr_lsb = ^{awaddr[L-1:0], araddr[L-1:0]};
        end
    endgenerate

    // Commit takes whichever half arrives now from the bus and the other half from its latch.
    always_comb begin
        c_idx  = aw_idx_q;
        c_data = wdata_q;
        c_strb = wstrb_q;
        if (wst == W_IDLE || wst == W_HAVE_W)
            c_idx = awaddr[A-1:L];
        if (wst == W_IDLE || wst == W_HAVE_AW) begin
            c_data = wdata;
            c_strb = wstrb;
        end
    end

    assign commit = (wst == W_IDLE    && aw_hs && w_hs) ||
                    (wst == W_HAVE_AW && w_hs) ||
                    (wst == W_HAVE_W  && aw_hs);

    // One-hot decode; an all-zero vector means the index is out of range.
    always_comb begin
        for (int r = 0; r < REGS; r++) begin
            wsel[r] = (c_idx  == IW'(r));
            rsel[r] = (ar_idx == IW'(r));
        end
    end

    assign w_err = ~|wsel || |(wsel & RO_MASK);

    // Reads see the flop contents, so a same-edge write is not yet visible.
    always_comb begin
        rd_word = '0;
        for (int r = 0; r < REGS; r++) begin
            if (rsel[r])
                rd_word = RO_MASK[r] ? status_d[r*DW +: DW] : regs[r];
        end
    end

    // Write path FSM with registered readys, response and register storage.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wst      <= W_IDLE;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            aw_idx_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            wr_pulse <= '0;
            for (int r = 0; r < REGS; r++)
                regs[r] <= RO_MASK[r] ? '0 : RESET_VAL[r*DW +: DW];
        end else begin
            wr_pulse <= '0;
            if (commit && !w_err) begin
                wr_pulse <= wsel;
                for (int r = 0; r < REGS; r++) begin
                    if (wsel[r]) begin
                        for (int b = 0; b < N; b++) begin
                            if (USE_STRB == 0 || c_strb[b])
                                regs[r][8*b +: 8] <= c_data[8*b +: 8];
                        end
                    end
                end
            end

            if (commit) begin
                wst     <= W_RESP;
                awready <= 1'b0;
                wready  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= w_err ? RESP_SLVERR : RESP_OKAY;
            end else begin
                case (wst)
                    W_IDLE: begin
                        if (aw_hs) begin
                            aw_idx_q <= awaddr[A-1:L];
                            wst      <= W_HAVE_AW;
                            awready  <= 1'b0;
                            wready   <= 1'b1;
                        end else if (w_hs) begin
                            wdata_q <= wdata;
                            wstrb_q <= wstrb;
                            wst     <= W_HAVE_W;
                            awready <= 1'b1;
                            wready  <= 1'b0;
                        end else begin
                            // Also raises the readys on the first cycle out of reset.
                            awready <= 1'b1;
                            wready  <= 1'b1;
                        end
                    end
                    W_HAVE_AW, W_HAVE_W: ;
                    W_RESP: begin
                        if (bready) begin
                            wst     <= W_IDLE;
                            bvalid  <= 1'b0;
                            bresp   <= RESP_OKAY;
                            awready <= 1'b1;
                            wready  <= 1'b1;
                        end
                    end
                    default: wst <= W_IDLE;
                endcase
            end
        end
    end

    // Read path FSM with registered data, response and strobe.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rst      <= R_IDLE;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rresp    <= RESP_OKAY;
            rd_pulse <= '0;
        end else begin
            rd_pulse <= '0;
            case (rst)
                R_IDLE: begin
                    if (ar_hs) begin
                        rdata    <= rd_word;
                        rresp    <= (|rsel) ? RESP_OKAY : RESP_SLVERR;
                        rd_pulse <= rsel;
                        rvalid   <= 1'b1;
                        arready  <= 1'b0;
                        rst      <= R_RESP;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                        rst     <= R_IDLE;
                    end
                end
                default: rst <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_reg_file.sv
// Testbench for axi4_lite_reg_file: directed steps plus randomized traffic checked against an array model.
// Two instances share stimulus: one with byte strobes, one with strobes ignored.
// Outputs are sampled 1 time unit after each rising edge, where new inputs are also driven.
module tb_axi4_lite_reg_file;

    localparam logic [15:0] ROM = 16'h0020;   // register 5 is read-only

    function automatic logic [511:0] mk_rst();
        logic [511:0] v;
        for (int r = 0; r < 16; r++) v[r*32 +: 32] = 32'hA5A5_0000 + 32'(r);
        return v;
    endfunction
    localparam logic [511:0] RV = mk_rst();

    logic         aclk = 1'b0;
    logic         areset;
    logic [11:0]  awaddr, araddr;
    logic         awvalid, wvalid, bready, arvalid, rready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic [511:0] status_d;

    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [511:0] reg_q;
    logic [15:0]  wr_pulse, rd_pulse;

    logic         n_awready, n_wready, n_bvalid, n_arready, n_rvalid;
    logic [1:0]   n_bresp, n_rresp;
    logic [31:0]  n_rdata;
    logic [511:0] n_reg_q;
    logic [15:0]  n_wr_pulse, n_rd_pulse;

    int errors = 0;
    int checks = 0;

    logic [31:0] m   [16];   // model with strobes
    logic [31:0] mns [16];   // model with strobes ignored

    always #5 aclk = ~aclk;

    axi4_lite_reg_file #(.A(12), .N(4), .REGS(16), .USE_STRB(1), .RO_MASK(ROM), .RESET_VAL(RV)) dut (
        .aclk(aclk), .areset(areset),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .reg_q(reg_q), .status_d(status_d), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
    );

    axi4_lite_reg_file #(.A(12), .N(4), .REGS(16), .USE_STRB(0), .RO_MASK(ROM), .RESET_VAL(RV)) dut_ns (
        .aclk(aclk), .areset(areset),
        .awaddr(awaddr), .awvalid(awvalid), .awready(n_awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(n_wready),
        .bresp(n_bresp), .bvalid(n_bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(n_arready),
        .rdata(n_rdata), .rresp(n_rresp), .rvalid(n_rvalid), .rready(rready),
        .reg_q(n_reg_q), .status_d(status_d), .wr_pulse(n_wr_pulse), .rd_pulse(n_rd_pulse)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 16; r++) begin
            m[r]   = ROM[r] ? 32'h0 : 32'hA5A5_0000 + 32'(r);
            mns[r] = m[r];
        end
    endtask

    task automatic check_regs();
        for (int r = 0; r < 16; r++) begin
            check($sformatf("reg_q[%0d]", r),   64'(reg_q[r*32 +: 32]),   64'(ROM[r] ? 32'h0 : m[r]));
            check($sformatf("ns_reg_q[%0d]", r), 64'(n_reg_q[r*32 +: 32]), 64'(ROM[r] ? 32'h0 : mns[r]));
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_readys", {awready, wready, arready}, 3'b000);
        check("rst_valids", {bvalid, rvalid}, 2'b00);
        check("rst_resps", {bresp, rresp}, 4'b0000);
        check("rst_rdata", rdata, 32'h0);
        check("rst_pulses", {wr_pulse, rd_pulse}, 32'h0);
    endtask

    task automatic do_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int awd, input int wd, input int hold);
        bit          aw_done, w_done, aw_acc, w_acc, ok;
        int          t, idx;
        logic [1:0]  eresp;
        logic [15:0] epulse;
        aw_done = 0; w_done = 0; t = 0;
        awaddr = addr; wdata = data; wstrb = strb;
        while (!(aw_done && w_done) && t < 40) begin
            awvalid = (t >= awd) && !aw_done;
            wvalid  = (t >= wd) && !w_done;
            aw_acc  = awvalid && awready;
            w_acc   = wvalid && wready;
            tick();
            t++;
            if (aw_acc) aw_done = 1;
            if (w_acc)  w_done = 1;
            // Scramble captured channels so the commit must use latched values.
            if (aw_done && !w_done) awaddr = 12'($urandom);
            if (w_done && !aw_done) begin wdata = $urandom; wstrb = 4'($urandom); end
            if (!(aw_done && w_done)) check("bvalid_early", bvalid, 1'b0);
        end
        awvalid = 0; wvalid = 0;
        check("write_timeout", aw_done && w_done, 1'b1);
        idx = int'(addr >> 2);
        ok  = (idx < 16) && !ROM[idx];
        if (ok) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) m[idx][8*b +: 8] = data[8*b +: 8];
            mns[idx] = data;
        end
        eresp  = ok ? 2'b00 : 2'b10;
        epulse = ok ? (16'd1 << idx) : 16'd0;
        check("bvalid", bvalid, 1'b1);
        check("bresp", bresp, eresp);
        check("wr_pulse", wr_pulse, epulse);
        check("wreadys_busy", {awready, wready}, 2'b00);
        check_regs();
        bready = 0;
        for (int h = 0; h < hold; h++) begin
            tick();
            check("bvalid_hold", bvalid, 1'b1);
            check("bresp_hold", bresp, eresp);
            check("wr_pulse_once", wr_pulse, 16'd0);
            check("wreadys_hold", {awready, wready}, 2'b00);
        end
        bready = 1;
        tick();
        bready = 0;
        check("bvalid_done", bvalid, 1'b0);
        check("wreadys_back", {awready, wready}, 2'b11);
        check("wr_pulse_after", wr_pulse, 16'd0);
    endtask

    task automatic do_read(input logic [11:0] addr, input int hold);
        int          idx, t;
        logic [31:0] ed;
        logic [1:0]  er;
        logic [15:0] ep;
        idx = int'(addr >> 2);
        t = 0;
        araddr = addr;
        arvalid = 1;
        while (!arready && t < 20) begin tick(); t++; end
        check("read_timeout", arready, 1'b1);
        if (idx < 16) begin
            ed = ROM[idx] ? status_d[idx*32 +: 32] : m[idx];
            er = 2'b00;
            ep = 16'd1 << idx;
        end else begin
            ed = 32'h0; er = 2'b10; ep = 16'd0;
        end
        tick();
        arvalid = 0;
        check("rvalid", rvalid, 1'b1);
        check("rdata", rdata, ed);
        check("rresp", rresp, er);
        check("rd_pulse", rd_pulse, ep);
        check("arready_busy", arready, 1'b0);
        rready = 0;
        for (int h = 0; h < hold; h++) begin
            tick();
            check("rvalid_hold", rvalid, 1'b1);
            check("rdata_hold", rdata, ed);
            check("rresp_hold", rresp, er);
            check("rd_pulse_once", rd_pulse, 16'd0);
            check("arready_hold", arready, 1'b0);
        end
        rready = 1;
        tick();
        rready = 0;
        check("rvalid_done", rvalid, 1'b0);
        check("arready_back", arready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old3, new3;
        logic [11:0] a;

        areset = 1; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        for (int r = 0; r < 16; r++) status_d[r*32 +: 32] = $urandom;
        status_d[5*32 +: 32] = 32'h0000_1234;
        model_reset();

        // Reset behaviour
        tick(); tick(); tick();
        check_reset_outputs();
        check_regs();
        areset = 0;
        tick();
        check("readys_after_reset", {awready, wready, arready}, 3'b111);

        // Read back every reset value
        for (int r = 0; r < 16; r++) do_read(12'(r * 4), 0);

        // Write ordering: AW first, W first, both together
        do_write(12'h008, 32'hDEAD_BEEF, 4'hF, 0, 3, 0);
        check("deadbeef_aw_first", reg_q[2*32 +: 32], 32'hDEAD_BEEF);
        do_write(12'h00C, 32'h0BAD_F00D, 4'hF, 3, 0, 0);
        do_write(12'h008, 32'hCAFE_1234, 4'hF, 0, 0, 1);

        // Strobes
        do_write(12'h004, 32'h1122_3344, 4'hF, 0, 0, 0);
        do_write(12'h004, 32'hAABB_CCDD, 4'b0101, 1, 0, 0);
        check("strb_merge", reg_q[1*32 +: 32], 32'h11BB_33DD);
        check("strb_ignored", n_reg_q[1*32 +: 32], 32'hAABB_CCDD);
        do_write(12'h004, 32'h5555_5555, 4'b0000, 0, 0, 0);

        // Errors: out of range, read-only, unaligned address
        do_write(12'h040, 32'h1234_5678, 4'hF, 0, 0, 0);
        do_write(12'h014, 32'hFFFF_FFFF, 4'hF, 0, 2, 0);
        do_read(12'h014, 0);
        check("ro_status_read", rdata, 32'h0000_1234);
        do_read(12'h040, 0);
        do_read(12'h00B, 1);

        // Backpressure with same-edge read and write of register 3
        old3 = m[3];
        new3 = ~old3;
        awaddr = 12'h00C; wdata = new3; wstrb = 4'hF; araddr = 12'h00C;
        check("pre_conc_readys", {awready, wready, arready}, 3'b111);
        awvalid = 1; wvalid = 1; arvalid = 1;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        m[3] = new3; mns[3] = new3;
        check("conc_rdata_old", rdata, old3);
        check("conc_rvalid", rvalid, 1'b1);
        check("conc_bvalid", bvalid, 1'b1);
        check("conc_bresp", bresp, 2'b00);
        check("conc_pulses", {wr_pulse, rd_pulse}, {16'h0008, 16'h0008});
        check_regs();
        for (int h = 0; h < 5; h++) begin
            tick();
            check("bp_valids", {bvalid, rvalid}, 2'b11);
            check("bp_rdata", rdata, old3);
            check("bp_resps", {bresp, rresp}, 4'b0000);
            check("bp_readys", {awready, wready, arready}, 3'b000);
            check("bp_pulses", {wr_pulse, rd_pulse}, 32'h0);
        end
        bready = 1; rready = 1;
        tick();
        bready = 0; rready = 0;
        check("bp_valids_done", {bvalid, rvalid}, 2'b00);
        check("bp_readys_back", {awready, wready, arready}, 3'b111);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            a = 12'($urandom_range(0, 'h4F));
            if ($urandom_range(0, 3) == 0) status_d[5*32 +: 32] = $urandom;
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 2));
            else
                do_read(a, $urandom_range(0, 2));
        end

        // Reset in the middle of a write
        awaddr = 12'h008; wdata = 32'h7777_7777; wstrb = 4'hF;
        awvalid = 1;
        tick();
        awvalid = 0;
        check("mid_have_aw", {awready, wready, bvalid}, 3'b010);
        areset = 1;
        tick();
        check_reset_outputs();
        model_reset();
        areset = 0;
        tick();
        check("mid_readys_back", {awready, wready, arready}, 3'b111);
        check("mid_no_bvalid", bvalid, 1'b0);
        check_regs();
        tick();
        check("mid_no_bvalid_later", {bvalid, wr_pulse}, 17'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
